// File: rtl/pipe_adder_hs_pkg.sv
// Shared definitions for the pipelined handshake adder: chunk width helper,
// add/subtract mode encodings and the per-stage control record.
package pipe_adder_pkg;

    // Encoding of the FLAG input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Control bits that travel alongside the operands in every stage
    typedef struct packed {
        logic valid;
        logic carry;
        logic flag;
    } stage_ctrl_t;

    // Width of one carry chunk; WIDTH must be a multiple of STAGES
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_hs_add_chunk.sv
// Combinational CHUNK-bit adder slice. It reports the carry out of the slice
// and the carry into its top bit, so the top slice can derive signed overflow.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum  = w_full[CHUNK-1:0];
    assign o_cout = w_full[CHUNK];
    // The top sum bit is a ^ b ^ carry-in, so the carry into it can be recovered
    assign o_cmsb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ o_sum[CHUNK-1];

endmodule

// File: rtl/pipe_adder_hs.sv
// Pipelined WIDTH-bit add/subtract with a valid/ready handshake.
// Stage 0 registers the operands (B already inverted for subtract); stage k
// adds chunk k-1 using the carry left by stage k-1, while the upper operand
// chunks and the finished lower sum chunks ride along. Empty stages always
// advance, so bubbles collapse, and the ready chain gives full back-pressure.
// Optional build macro: PIPE_ADDER_SAT_EN enables signed saturation of S_out.
module pipe_adder_hs
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             FLAG,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S_out,
    output logic             C_out,
    output logic             OVF
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    stage_ctrl_t      r_ctrl [0:STAGES];
    logic [WIDTH-1:0] r_a    [0:STAGES-1];
    logic [WIDTH-1:0] r_b    [0:STAGES-1];
    logic [WIDTH-1:0] r_sum  [0:STAGES];
    logic             r_ovf;
    logic             r_readyEn;

    logic [STAGES:0]  w_adv;
    logic             w_inReady;
    logic [WIDTH-1:0] w_bEff;
    logic [CHUNK-1:0] w_chunkSum  [0:STAGES-1];
    logic             w_chunkCout [0:STAGES-1];
    logic             w_chunkCmsb [0:STAGES-1];
    logic [WIDTH-1:0] w_finalSum;
    logic             w_ovf;

    // One adder slice per stage, each working on its own chunk of the operands
    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        add_chunk #(.CHUNK(CHUNK)) u_addChunk (
            .i_a    (r_a[k][k*CHUNK +: CHUNK]),
            .i_b    (r_b[k][k*CHUNK +: CHUNK]),
            .i_cin  (r_ctrl[k].carry),
            .o_sum  (w_chunkSum[k]),
            .o_cout (w_chunkCout[k]),
            .o_cmsb (w_chunkCmsb[k])
        );
    end

    // Select the effective B operand from the mode input
    always_comb begin
        w_bEff = B;
        case (FLAG)
            MODE_ADD: w_bEff = B;
            MODE_SUB: w_bEff = ~B;
            default:  w_bEff = B;
        endcase
    end

    // Ready chain from the output back to the input: a stage moves if it is empty or its successor moves
    always_comb begin
        logic [STAGES:0] adv;
        adv         = '0;
        adv[STAGES] = out_ready || !r_ctrl[STAGES].valid;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !r_ctrl[k].valid || adv[k+1];
        end
        w_adv = adv;
    end

    assign w_inReady = w_adv[0] && r_readyEn;
    assign in_ready  = w_inReady;

    // Assemble the final result, overflow flag and (optionally) the saturated value
    always_comb begin
        w_finalSum                    = r_sum[STAGES-1];
        w_finalSum[WIDTH-1 -: CHUNK]  = w_chunkSum[STAGES-1];
        w_ovf                         = w_chunkCout[STAGES-1] ^ w_chunkCmsb[STAGES-1];
`ifdef PIPE_ADDER_SAT_EN
        if (w_ovf) begin
            w_finalSum = r_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Pipeline registers: each stage loads from its predecessor whenever the ready chain lets it advance
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_readyEn <= 1'b0;
            r_ovf     <= 1'b0;
            for (int k = 0; k <= STAGES; k++) begin
                r_ctrl[k] <= '0;
                r_sum[k]  <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            r_readyEn <= 1'b1;

            if (w_adv[0]) begin
                r_ctrl[0].valid <= in_valid && w_inReady;
                if (in_valid && w_inReady) begin
                    r_a[0]          <= A;
                    r_b[0]          <= w_bEff;
                    r_ctrl[0].carry <= C_in;
                    r_ctrl[0].flag  <= FLAG;
                end
            end

            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_ctrl[k].valid <= r_ctrl[k-1].valid;
                    if (r_ctrl[k-1].valid) begin
                        r_a[k]                         <= r_a[k-1];
                        r_b[k]                         <= r_b[k-1];
                        r_ctrl[k].carry                <= w_chunkCout[k-1];
                        r_ctrl[k].flag                 <= r_ctrl[k-1].flag;
                        r_sum[k]                       <= r_sum[k-1];
                        r_sum[k][(k-1)*CHUNK +: CHUNK] <= w_chunkSum[k-1];
                    end
                end
            end

            if (w_adv[STAGES]) begin
                r_ctrl[STAGES].valid <= r_ctrl[STAGES-1].valid;
                if (r_ctrl[STAGES-1].valid) begin
                    r_ctrl[STAGES].carry <= w_chunkCout[STAGES-1];
                    r_ctrl[STAGES].flag  <= r_ctrl[STAGES-1].flag;
                    r_sum[STAGES]        <= w_finalSum;
                    r_ovf                <= w_ovf;
                end
            end
        end
    end

    assign out_valid = r_ctrl[STAGES].valid;
    assign S_out     = r_sum[STAGES];
    assign C_out     = r_ctrl[STAGES].carry;
    assign OVF       = r_ovf;

endmodule
